// File: rtl/id_scoreboard_stage.sv
// Decode-side operand stage: multi-port register file, per-register busy scoreboard, ID/EX register.
// Optional macro WB_BYPASS_EN: a same-cycle writeback unblocks a busy source and supplies its operand.
module id_scoreboard_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 4,
  parameter int NUM_WB   = 4,
  parameter int CTRL_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [ADDR_W-1:0]         id_dst_addr,
  input  logic                      id_dst_en,
  input  logic [15:0]               id_imm16,
  input  logic [CTRL_W-1:0]         id_ctrl,
  input  logic [NUM_WB-1:0]         wb_en,
  input  logic [NUM_WB*ADDR_W-1:0]  wb_addr,
  input  logic [NUM_WB*DATA_W-1:0]  wb_data,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [NUM_SRC*DATA_W-1:0] ex_src_data,
  output logic [DATA_W-1:0]         ex_imm,
  output logic [ADDR_W-1:0]         ex_dst_addr,
  output logic                      ex_dst_en,
  output logic [CTRL_W-1:0]         ex_ctrl,
  output logic                      stall,
  output logic [NUM_REGS-1:0]       busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // id_ready never looks at id_valid; ex_* stay stable while ex_valid & !ex_ready.

  logic [DATA_W-1:0]         rf_q [NUM_REGS];
  logic [DATA_W-1:0]         rf_d [NUM_REGS];
  logic [NUM_REGS-1:0]       busy_q, busy_d;
  logic                      ex_valid_q, ex_valid_d;
  logic [NUM_SRC*DATA_W-1:0] ex_src_q, ex_src_d;
  logic [DATA_W-1:0]         ex_imm_q, ex_imm_d;
  logic [ADDR_W-1:0]         ex_dst_addr_q, ex_dst_addr_d;
  logic                      ex_dst_en_q, ex_dst_en_d;
  logic [CTRL_W-1:0]         ex_ctrl_q, ex_ctrl_d;

  logic [ADDR_W-1:0]         src_a [NUM_SRC];
  logic [ADDR_W-1:0]         wb_a  [NUM_WB];
  logic [DATA_W-1:0]         wb_d  [NUM_WB];
  logic [NUM_SRC-1:0]        src_blocked;
  logic [NUM_SRC*DATA_W-1:0] rd_data;
  logic                      waw;
  logic                      issue;

  // r0 and out-of-range addresses never hold state.
  function automatic logic reg_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) src_a[i] = id_src_addr[i*ADDR_W +: ADDR_W];
    for (int k = 0; k < NUM_WB; k++) begin
      wb_a[k] = wb_addr[k*ADDR_W +: ADDR_W];
      wb_d[k] = wb_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef WB_BYPASS_EN
  logic [NUM_SRC-1:0] src_fwd;
  logic [DATA_W-1:0]  fwd_data [NUM_SRC];

  // Highest-numbered matching port supplies the forwarded value.
  always_comb begin
    src_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_data[i] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_en[k] && (wb_a[k] == src_a[i])) begin
          src_fwd[i]  = 1'b1;
          fwd_data[i] = wb_d[k];
        end
      end
    end
  end
`endif

  always_comb begin
    src_blocked = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && reg_ok(src_a[i]) && busy_q[src_a[i]]) begin
`ifdef WB_BYPASS_EN
        src_blocked[i] = !src_fwd[i];
`else
        src_blocked[i] = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reg_ok(src_a[i])) rd_data[i*DATA_W +: DATA_W] = rf_q[src_a[i]];
`ifdef WB_BYPASS_EN
      if (reg_ok(src_a[i]) && src_fwd[i]) rd_data[i*DATA_W +: DATA_W] = fwd_data[i];
`endif
    end
  end

  assign waw      = id_dst_en && reg_ok(id_dst_addr) && busy_q[id_dst_addr];
  assign id_ready = !flush && (src_blocked == '0) && !waw && (!ex_valid_q || ex_ready);
  assign issue    = id_valid && id_ready;
  assign stall    = id_valid && !id_ready;

  // Later ports overwrite earlier ones, so the highest k wins on an address clash.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) rf_d[r] = rf_q[r];
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_en[k] && reg_ok(wb_a[k])) rf_d[wb_a[k]] = wb_d[k];
    end
  end

  // Clears first, then the issue set, so a new producer outranks a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_en[k] && reg_ok(wb_a[k])) busy_d[wb_a[k]] = 1'b0;
    end
    if (flush && ex_valid_q && ex_dst_en_q && reg_ok(ex_dst_addr_q)) busy_d[ex_dst_addr_q] = 1'b0;
    if (issue && id_dst_en && reg_ok(id_dst_addr)) busy_d[id_dst_addr] = 1'b1;
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_src_d      = ex_src_q;
    ex_imm_d      = ex_imm_q;
    ex_dst_addr_d = ex_dst_addr_q;
    ex_dst_en_d   = ex_dst_en_q;
    ex_ctrl_d     = ex_ctrl_q;
    if (issue) begin
      ex_valid_d    = 1'b1;
      ex_src_d      = rd_data;
      ex_imm_d      = DATA_W'(signed'(id_imm16));
      ex_dst_addr_d = id_dst_addr;
      ex_dst_en_d   = id_dst_en;
      ex_ctrl_d     = id_ctrl;
    end else if (flush || ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
      busy_q        <= '0;
      ex_valid_q    <= 1'b0;
      ex_src_q      <= '0;
      ex_imm_q      <= '0;
      ex_dst_addr_q <= '0;
      ex_dst_en_q   <= 1'b0;
      ex_ctrl_q     <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= rf_d[r];
      busy_q        <= busy_d;
      ex_valid_q    <= ex_valid_d;
      ex_src_q      <= ex_src_d;
      ex_imm_q      <= ex_imm_d;
      ex_dst_addr_q <= ex_dst_addr_d;
      ex_dst_en_q   <= ex_dst_en_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_src_data = ex_src_q;
  assign ex_imm      = ex_imm_q;
  assign ex_dst_addr = ex_dst_addr_q;
  assign ex_dst_en   = ex_dst_en_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Bench for id_scoreboard_stage: directed scenarios, a hazard vector table and
// randomized traffic compared against a register-array / packet-queue reference model.
module tb_id_scoreboard_stage;
  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int AW    = 5;
  localparam int NS    = 4;
  localparam int NWB   = 4;
  localparam int CW    = 16;
  localparam int S_LO  = 0;
  localparam int I_LO  = NS*DW;
  localparam int C_LO  = I_LO + DW;
  localparam int D_LO  = C_LO + CW;
  localparam int E_BIT = D_LO + AW;
  localparam int PKT_W = E_BIT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              id_valid, id_ready, id_dst_en, flush, ex_valid, ex_ready;
  logic [NS*AW-1:0]  id_src_addr;
  logic [NS-1:0]     id_src_used;
  logic [AW-1:0]     id_dst_addr, ex_dst_addr;
  logic [15:0]       id_imm16;
  logic [CW-1:0]     id_ctrl, ex_ctrl;
  logic [NWB-1:0]    wb_en;
  logic [NWB*AW-1:0] wb_addr;
  logic [NWB*DW-1:0] wb_data;
  logic [NS*DW-1:0]  ex_src_data;
  logic [DW-1:0]     ex_imm;
  logic              ex_dst_en, stall;
  logic [NR-1:0]     busy;

  id_scoreboard_stage #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_SRC(NS), .NUM_WB(NWB), .CTRL_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_dst_en(id_dst_en), .id_imm16(id_imm16), .id_ctrl(id_ctrl), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_src_data(ex_src_data), .ex_imm(ex_imm),
    .ex_dst_addr(ex_dst_addr), .ex_dst_en(ex_dst_en), .ex_ctrl(ex_ctrl),
    .stall(stall), .busy(busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]    m_rf [NR];
  logic [NR-1:0]    m_busy;
  logic [PKT_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] src_of(input int i);
    return id_src_addr[i*AW +: AW];
  endfunction
  function automatic logic [AW-1:0] wba_of(input int k);
    return wb_addr[k*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] wbd_of(input int k);
    return wb_data[k*DW +: DW];
  endfunction

  function automatic logic wb_hits(input logic [AW-1:0] a);
    for (int k = 0; k < NWB; k++) if (wb_en[k] && wba_of(k) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] wb_last(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < NWB; k++) if (wb_en[k] && wba_of(k) == a) v = wbd_of(k);
    return v;
  endfunction

  function automatic logic model_ready();
    logic blocked;
    logic [AW-1:0] a;
    blocked = 1'b0;
    for (int i = 0; i < NS; i++) begin
      a = src_of(i);
      if (id_src_used[i] && a != 0 && m_busy[a]) begin
`ifdef WB_BYPASS_EN
        if (!wb_hits(a)) blocked = 1'b1;
`else
        blocked = 1'b1;
`endif
      end
    end
    if (id_dst_en && id_dst_addr != 0 && m_busy[id_dst_addr]) blocked = 1'b1;
    return !flush && !blocked && (exp_q.size() == 0 || ex_ready);
  endfunction

  function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (wb_hits(a)) return wb_last(a);
`endif
    return m_rf[a];
  endfunction

  function automatic logic [PKT_W-1:0] model_pkt();
    logic [NS*DW-1:0] s;
    logic [DW-1:0] imm;
    for (int i = 0; i < NS; i++) s[i*DW +: DW] = model_operand(src_of(i));
    imm = (id_imm16 >= 16'h8000) ? DW'(id_imm16) - DW'(32'h10000) : DW'(id_imm16);
    return {id_dst_en, id_dst_addr, id_ctrl, imm, s};
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_rf[r] = '0;
    m_busy = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic issue;
    logic [PKT_W-1:0] pkt, front;
    logic [NR-1:0] nb;
    issue = id_valid && model_ready();
    pkt   = model_pkt();
    nb    = m_busy;
    for (int k = 0; k < NWB; k++) if (wb_en[k] && wba_of(k) != 0) nb[wba_of(k)] = 1'b0;
    if (flush && exp_q.size() != 0) begin
      front = exp_q[0];
      if (front[E_BIT] && front[D_LO +: AW] != 0) nb[front[D_LO +: AW]] = 1'b0;
    end
    if (issue && id_dst_en && id_dst_addr != 0) nb[id_dst_addr] = 1'b1;
    for (int k = 0; k < NWB; k++) if (wb_en[k] && wba_of(k) != 0) m_rf[wba_of(k)] = wbd_of(k);
    if (exp_q.size() != 0 && (flush || ex_ready)) void'(exp_q.pop_front());
    if (issue) exp_q.push_back(pkt);
    m_busy = nb;
  endtask

  task automatic check_state();
    logic [PKT_W-1:0] p;
    chk("ex_valid", 128'(ex_valid), 128'(exp_q.size() != 0));
    chk("busy", 128'(busy), 128'(m_busy));
    if (exp_q.size() != 0) begin
      p = exp_q[0];
      chk("ex_src_data", 128'(ex_src_data), 128'(p[S_LO +: NS*DW]));
      chk("ex_imm", 128'(ex_imm), 128'(p[I_LO +: DW]));
      chk("ex_ctrl", 128'(ex_ctrl), 128'(p[C_LO +: CW]));
      chk("ex_dst_addr", 128'(ex_dst_addr), 128'(p[D_LO +: AW]));
      chk("ex_dst_en", 128'(ex_dst_en), 128'(p[E_BIT]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_valid = 0; id_src_addr = '0; id_src_used = '0; id_dst_addr = '0; id_dst_en = 0;
    id_imm16 = '0; id_ctrl = '0; wb_en = '0; wb_addr = '0; wb_data = '0; flush = 0; ex_ready = 0;
  endtask

  function automatic logic [NS*AW-1:0] pack_src(input logic [AW-1:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic set_instr(input logic [AW-1:0] s0, s1, s2, s3, input logic [NS-1:0] used,
                           input logic [AW-1:0] dst, input logic den, input logic [15:0] imm,
                           input logic [CW-1:0] ctrl);
    id_valid = 1; id_src_addr = pack_src(s0, s1, s2, s3); id_src_used = used;
    id_dst_addr = dst; id_dst_en = den; id_imm16 = imm; id_ctrl = ctrl;
  endtask

  task automatic set_wb(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_en[k] = 1'b1;
    wb_addr[k*AW +: AW] = a;
    wb_data[k*DW +: DW] = d;
  endtask

  task automatic peek();
    #1;
  endtask

  // One clock: check combinational outputs, advance model and DUT, check registered state.
  task automatic cycle();
    #1;
    chk("id_ready", 128'(id_ready), 128'(model_ready()));
    chk("stall", 128'(stall), 128'(id_valid && !model_ready()));
    model_edge();
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
  endtask

  typedef struct {
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]    used;
    logic [AW-1:0]    dst;
    logic             den;
    logic             fl;
    logic             exr;
    logic             exp_ready;
  } hz_vec_t;
  hz_vec_t hz_tab [10];

  initial begin
    // busy = {r4, r5, r7} and ex_valid = 1 when this table is applied.
    hz_tab[0] = '{pack_src(1, 0, 0, 0), 4'b0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    hz_tab[1] = '{pack_src(4, 0, 0, 0), 4'b0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    hz_tab[2] = '{pack_src(4, 0, 0, 0), 4'b0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    hz_tab[3] = '{pack_src(0, 0, 0, 5), 4'b1000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    hz_tab[4] = '{pack_src(0, 0, 0, 0), 4'b0000, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0};
    hz_tab[5] = '{pack_src(0, 0, 0, 0), 4'b0000, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1};
    hz_tab[6] = '{pack_src(0, 0, 0, 0), 4'b0000, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    hz_tab[7] = '{pack_src(1, 0, 0, 0), 4'b0001, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    hz_tab[8] = '{pack_src(1, 0, 0, 0), 4'b0001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    hz_tab[9] = '{pack_src(0, 0, 8, 0), 4'b0100, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1};

    idle();
    model_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst.ex_valid", 128'(ex_valid), 128'(0));
    chk("rst.ex_src_data", 128'(ex_src_data), 128'(0));
    chk("rst.ex_imm", 128'(ex_imm), 128'(0));
    chk("rst.ex_dst", 128'({ex_dst_en, ex_dst_addr}), 128'(0));
    chk("rst.ex_ctrl", 128'(ex_ctrl), 128'(0));
    chk("rst.busy", 128'(busy), 128'(0));
    chk("rst.id_ready", 128'(id_ready), 128'(1));
    rst = 0;
    @(negedge clk);

    // Basic issue r3 <- (r1, r2)
    set_wb(0, 1, 32'd5); set_wb(1, 2, 32'd7);
    cycle();
    idle();
    set_instr(1, 2, 0, 0, 4'b0011, 3, 1, 16'h0004, 16'hABCD); ex_ready = 1;
    cycle();
    chk("t1.ex_valid", 128'(ex_valid), 128'(1));
    chk("t1.src0", 128'(ex_src_data[31:0]), 128'(5));
    chk("t1.src1", 128'(ex_src_data[63:32]), 128'(7));
    chk("t1.busy3", 128'(busy[3]), 128'(1));
    chk("t1.imm_ctrl", 128'({ex_imm, ex_ctrl}), 128'({32'h4, 16'hABCD}));

    // RAW stall on r3 until writeback
    set_instr(3, 0, 0, 0, 4'b0001, 5, 1, 16'h0010, 16'h0002); ex_ready = 1;
    peek(); chk("t2.stall_a", 128'(stall), 128'(1));
    cycle();
    peek(); chk("t2.stall_b", 128'(stall), 128'(1));
    cycle();
    set_wb(0, 3, 32'h2A);
`ifdef WB_BYPASS_EN
    peek(); chk("t2.stall_wb", 128'(stall), 128'(0));
    cycle();
`else
    peek(); chk("t2.stall_wb", 128'(stall), 128'(1));
    cycle();
    wb_en = '0;
    peek(); chk("t2.stall_after", 128'(stall), 128'(0));
    cycle();
`endif
    chk("t2.ex_valid", 128'(ex_valid), 128'(1));
    chk("t2.src0", 128'(ex_src_data[31:0]), 128'(32'h2A));
    chk("t2.dst", 128'(ex_dst_addr), 128'(5));

    // EX backpressure for three cycles
    idle();
    set_instr(1, 0, 0, 0, 4'b0001, 7, 1, 16'h7FFF, 16'h1234); ex_ready = 0;
    for (int n = 0; n < 3; n++) begin
      peek(); chk("t3.id_ready_hold", 128'(id_ready), 128'(0));
      cycle();
      chk("t3.hold", 128'({ex_valid, ex_dst_addr, ex_src_data[31:0]}), 128'({1'b1, 5'd5, 32'h2A}));
    end
    ex_ready = 1;
    peek(); chk("t3.id_ready_rel", 128'(id_ready), 128'(1));
    cycle();
    chk("t3.next", 128'({ex_dst_addr, ex_src_data[31:0], ex_imm}), 128'({5'd7, 32'd5, 32'h7FFF}));
    idle(); ex_ready = 1;
    cycle();
    chk("t3.drain", 128'(ex_valid), 128'(0));

    // Flush drops the in-EX producer only
    set_instr(0, 0, 0, 0, 4'b0000, 4, 1, 16'h0, 16'h0); ex_ready = 1;
    cycle();
    set_instr(0, 0, 0, 0, 4'b0000, 9, 1, 16'h0, 16'h0); ex_ready = 1;
    cycle();
    idle(); flush = 1;
    peek(); chk("t4.id_ready_flush", 128'(id_ready), 128'(0));
    cycle();
    chk("t4.flush", 128'({ex_valid, busy[9], busy[4]}), 128'(3'b001));
    idle();
    set_instr(0, 0, 0, 0, 4'b0000, 10, 1, 16'h0, 16'h0); ex_ready = 1;
    cycle();
    idle(); flush = 1; set_wb(2, 10, 32'h55);
    cycle();
    chk("t4.flush_wb", 128'({ex_valid, busy[10]}), 128'(0));

    // Multi-port WB clash plus issue-set on the same register
    idle();
    set_instr(0, 0, 0, 0, 4'b0000, 6, 1, 16'h8001, 16'h00C3); ex_ready = 1;
    set_wb(1, 6, 32'h11); set_wb(3, 6, 32'h33);
    cycle();
    chk("t5.busy6", 128'(busy[6]), 128'(1));
    chk("t5.imm", 128'(ex_imm), 128'(32'hFFFF8001));
    idle(); flush = 1;
    cycle();
    chk("t5.busy6_flush", 128'(busy[6]), 128'(0));
    idle();
    set_instr(6, 0, 0, 0, 4'b0001, 0, 0, 16'h0, 16'h0); ex_ready = 0;
    cycle();
    chk("t5.rf6", 128'(ex_src_data[31:0]), 128'(32'h33));
    idle();
    chk("tab.busy_setup", 128'(busy), 128'(32'h0000_00B0));

    // Hazard table
    for (int i = 0; i < 10; i++) begin
      id_src_addr = hz_tab[i].src_addr; id_src_used = hz_tab[i].used;
      id_dst_addr = hz_tab[i].dst; id_dst_en = hz_tab[i].den;
      flush = hz_tab[i].fl; ex_ready = hz_tab[i].exr;
      #1;
      chk($sformatf("hz_tab[%0d]", i), 128'(id_ready), 128'(hz_tab[i].exp_ready));
      idle();
      @(negedge clk);
    end

    // Asynchronous reset mid-operation
    rst = 1;
    #1;
    chk("arst.ex_valid", 128'(ex_valid), 128'(0));
    chk("arst.busy", 128'(busy), 128'(0));
    chk("arst.ex_src", 128'(ex_src_data), 128'(0));
    model_reset();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    set_instr(1, 0, 0, 0, 4'b0001, 0, 0, 16'h0, 16'h0); ex_ready = 1;
    cycle();
    chk("arst.rf1", 128'(ex_src_data[31:0]), 128'(0));

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      id_valid = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NS; i++) begin
        id_src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        id_src_used[i] = 1'($urandom_range(0, 1));
      end
      id_dst_addr = AW'($urandom_range(0, 7));
      id_dst_en = ($urandom_range(0, 3) != 0);
      id_imm16 = 16'($urandom);
      id_ctrl = CW'($urandom);
      for (int k = 0; k < NWB; k++) begin
        wb_en[k] = ($urandom_range(0, 9) < 2);
        wb_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        wb_data[k*DW +: DW] = DW'($urandom);
      end
      flush = ($urandom_range(0, 19) == 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
